// File: rtl/gpio_bank_if.sv
// Register-write bus between the register decoder (master) and the GPIO bank (slave).
interface gpio_bank_if #(
    parameter int unsigned WIDTH = 16
) ();
    logic             wr_en;
    logic [3:0]       wr_sel;
    logic [WIDTH-1:0] wr_data;

    modport master (output wr_en, output wr_sel, output wr_data);
    modport slave  (input  wr_en, input  wr_sel, input  wr_data);
endinterface

// File: rtl/gpio_bank.sv
// GPIO bank: direction/data registers with atomic set/clear/toggle, synchronised and
// debounced inputs, per-pin edge/level interrupt detection with sticky W1C status.
module gpio_bank #(
    parameter int unsigned WIDTH        = 16,
    parameter int unsigned SYNC_STAGES  = 2,
    parameter int unsigned DEBOUNCE_CYC = 4
) (
    input  logic             clk,
    input  logic             reset,
    gpio_bank_if.slave       bus,
    input  logic [WIDTH-1:0] pins_in,
    output logic [WIDTH-1:0] pins_out,
    output logic [WIDTH-1:0] pins_oe,
    output logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] dir_q,
    output logic [WIDTH-1:0] irq_status,
    output logic             irq
);

    typedef enum logic [3:0] {
        SEL_DATA     = 4'd0,
        SEL_SET      = 4'd1,
        SEL_CLR      = 4'd2,
        SEL_TOG      = 4'd3,
        SEL_DIR      = 4'd4,
        SEL_IRQ_EN   = 4'd5,
        SEL_IRQ_TYPE = 4'd6,
        SEL_IRQ_POL  = 4'd7,
        SEL_IRQ_BOTH = 4'd8,
        SEL_IRQ_W1C  = 4'd9
    } sel_e;

    localparam int unsigned CNT_W = (DEBOUNCE_CYC > 0) ? $clog2(DEBOUNCE_CYC + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((DEBOUNCE_CYC > 0) ? DEBOUNCE_CYC - 1 : 0);

    logic [WIDTH-1:0] wdata;
    logic             wen;
    logic [3:0]       wsel;

    logic [WIDTH-1:0] data_r;
    logic [WIDTH-1:0] dir_r;
    logic [WIDTH-1:0] en_r;
    logic [WIDTH-1:0] type_r;
    logic [WIDTH-1:0] pol_r;
    logic [WIDTH-1:0] both_r;
    logic [WIDTH-1:0] status_r;

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] filt_q;
    logic [WIDTH-1:0] prev_q;

    logic [WIDTH-1:0] w1c;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] edge_ev;
    logic [WIDTH-1:0] level_ev;

    assign wen   = bus.wr_en;
    assign wsel  = bus.wr_sel;
    assign wdata = bus.wr_data;

    // Control registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            data_r <= '0;
            dir_r  <= '0;
            en_r   <= '0;
            type_r <= '0;
            pol_r  <= '0;
            both_r <= '0;
        end else if (wen) begin
            case (wsel)
                SEL_DATA:     data_r <= wdata;
                SEL_SET:      data_r <= data_r | wdata;
                SEL_CLR:      data_r <= data_r & ~wdata;
                SEL_TOG:      data_r <= data_r ^ wdata;
                SEL_DIR:      dir_r  <= wdata;
                SEL_IRQ_EN:   en_r   <= wdata;
                SEL_IRQ_TYPE: type_r <= wdata;
                SEL_IRQ_POL:  pol_r  <= wdata;
                SEL_IRQ_BOTH: both_r <= wdata;
                default:      ;
            endcase
        end
    end

    // Input synchroniser chain
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= pins_in;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    generate
        if (DEBOUNCE_CYC == 0) begin : g_no_debounce
            always_ff @(posedge clk) begin
                if (!reset) begin
                    filt_q <= '0;
                end else begin
                    filt_q <= s;
                end
            end
        end else begin : g_debounce
            logic [CNT_W-1:0] cnt_q [WIDTH];

            // Counter only runs while s disagrees with filt; any return to filt restarts it.
            always_ff @(posedge clk) begin
                if (!reset) begin
                    filt_q <= '0;
                    for (int unsigned i = 0; i < WIDTH; i++) begin
                        cnt_q[i] <= '0;
                    end
                end else begin
                    for (int unsigned i = 0; i < WIDTH; i++) begin
                        if (s[i] == filt_q[i]) begin
                            cnt_q[i] <= '0;
                        end else if (cnt_q[i] == CNT_LAST) begin
                            filt_q[i] <= s[i];
                            cnt_q[i]  <= '0;
                        end else begin
                            cnt_q[i] <= cnt_q[i] + 1'b1;
                        end
                    end
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!reset) begin
            prev_q <= '0;
        end else begin
            prev_q <= filt_q;
        end
    end

    always_comb begin
        w1c      = (wen && (wsel == SEL_IRQ_W1C)) ? wdata : '0;
        rise     = filt_q & ~prev_q;
        fall     = ~filt_q & prev_q;
        edge_ev  = ~type_r & ((both_r & (filt_q ^ prev_q)) |
                              (~both_r & ~pol_r & rise) |
                              (~both_r & pol_r & fall));
        level_ev = type_r & ~(filt_q ^ pol_r);
    end

    // Edge events beat a same-cycle W1C; a level event yields to it for one
    // cycle and re-sets on the next edge if the level is still active.
    always_ff @(posedge clk) begin
        if (!reset) begin
            status_r <= '0;
        end else begin
            status_r <= (status_r & ~w1c) | edge_ev | (level_ev & ~w1c);
        end
    end

    assign pins_out   = data_r;
    assign pins_oe    = dir_r;
    assign dir_q      = dir_r;
    assign data_in    = (dir_r & data_r) | (~dir_r & filt_q);
    assign irq_status = status_r;
    assign irq        = |(status_r & en_r);

endmodule

// File: tb/tb_gpio_bank.sv
// Directed bench for gpio_bank with a scoreboard queue of expected observations.
module tb_gpio_bank;

    logic        clk;
    logic        reset;
    logic [15:0] pins_in;
    logic [15:0] pins_out;
    logic [15:0] pins_oe;
    logic [15:0] data_in;
    logic [15:0] dir_q;
    logic [15:0] irq_status;
    logic        irq;

    int checks = 0;
    int errors = 0;

    gpio_bank_if #(.WIDTH(16)) bus ();

    gpio_bank #(
        .WIDTH(16),
        .SYNC_STAGES(2),
        .DEBOUNCE_CYC(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus),
        .pins_in(pins_in),
        .pins_out(pins_out),
        .pins_oe(pins_oe),
        .data_in(data_in),
        .dir_q(dir_q),
        .irq_status(irq_status),
        .irq(irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef enum int { O_OUT, O_OE, O_DIN, O_DIR, O_STAT, O_IRQ } obs_e;

    typedef struct {
        string       tag;
        obs_e        sig;
        logic [15:0] mask;
        logic [15:0] exp;
    } exp_t;

    exp_t sbq[$];

    function automatic logic [15:0] sample(input obs_e sig);
        case (sig)
            O_OUT:   return pins_out;
            O_OE:    return pins_oe;
            O_DIN:   return data_in;
            O_DIR:   return dir_q;
            O_STAT:  return irq_status;
            default: return {15'b0, irq};
        endcase
    endfunction

    task automatic push(input string tag, input obs_e sig, input logic [15:0] mask,
                        input logic [15:0] exp);
        exp_t e;
        e.tag  = tag;
        e.sig  = sig;
        e.mask = mask;
        e.exp  = exp;
        sbq.push_back(e);
    endtask

    task automatic drain();
        while (sbq.size() > 0) begin
            exp_t        e;
            logic [15:0] o;
            e = sbq.pop_front();
            o = sample(e.sig) & e.mask;
            checks++;
            assert (o === e.exp)
            else begin
                errors++;
                $error("FAIL %s observed=%h expected=%h", e.tag, o, e.exp);
            end
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] sel, input logic [15:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_sel  = sel;
        bus.wr_data = d;
        step(1);
        bus.wr_en   = 1'b0;
        bus.wr_sel  = 4'd0;
        bus.wr_data = '0;
    endtask

    initial begin
        reset       = 1'b0;
        pins_in     = 16'hFFFF;
        bus.wr_en   = 1'b0;
        bus.wr_sel  = 4'd0;
        bus.wr_data = '0;

        // Reset state
        push("rst_out", O_OUT, 16'hFFFF, 16'h0000);
        push("rst_oe", O_OE, 16'hFFFF, 16'h0000);
        push("rst_dir", O_DIR, 16'hFFFF, 16'h0000);
        push("rst_din", O_DIN, 16'hFFFF, 16'h0000);
        push("rst_stat", O_STAT, 16'hFFFF, 16'h0000);
        push("rst_irq", O_IRQ, 16'h0001, 16'h0000);
        step(3);
        drain();
        reset = 1'b1;

        // Data register operations
        wr(4'd4, 16'h00FF);
        push("dir_oe", O_OE, 16'hFFFF, 16'h00FF);
        push("dir_q", O_DIR, 16'hFFFF, 16'h00FF);
        drain();
        wr(4'd0, 16'h00A5);
        push("data", O_OUT, 16'hFFFF, 16'h00A5);
        drain();
        wr(4'd1, 16'h0100);
        push("set", O_OUT, 16'hFFFF, 16'h01A5);
        drain();
        wr(4'd2, 16'h0004);
        push("clr", O_OUT, 16'hFFFF, 16'h01A1);
        drain();
        wr(4'd3, 16'h0003);
        push("tog", O_OUT, 16'hFFFF, 16'h01A2);
        drain();
        wr(4'd12, 16'hFFFF);
        push("sel_ignored", O_OUT, 16'hFFFF, 16'h01A2);
        drain();

        // Pins high through reset produce rising events after release
        push("held_high_stat", O_STAT, 16'hFFFF, 16'hFFFF);
        push("held_high_irq", O_IRQ, 16'h0001, 16'h0000);
        push("din_mixed", O_DIN, 16'hFFFF, 16'hFFA2);
        step(5);
        drain();

        pins_in = 16'h0000;
        wr(4'd4, 16'h0000);
        wr(4'd0, 16'h0000);
        step(10);
        wr(4'd9, 16'hFFFF);
        push("w1c_all", O_STAT, 16'hFFFF, 16'h0000);
        push("din_low", O_DIN, 16'hFFFF, 16'h0000);
        drain();

        // Rising edge on pin 0 with latency
        wr(4'd5, 16'h0001);
        pins_in = 16'h0001;
        push("p0_din_k5", O_DIN, 16'h0001, 16'h0000);
        step(5);
        drain();
        push("p0_din_k6", O_DIN, 16'h0001, 16'h0001);
        push("p0_stat_k6", O_STAT, 16'h0001, 16'h0000);
        step(1);
        drain();
        push("p0_stat_k7", O_STAT, 16'h0001, 16'h0001);
        push("p0_irq_k7", O_IRQ, 16'h0001, 16'h0001);
        step(1);
        drain();
        wr(4'd9, 16'h0001);
        push("p0_w1c_stat", O_STAT, 16'h0001, 16'h0000);
        push("p0_w1c_irq", O_IRQ, 16'h0001, 16'h0000);
        drain();

        // Debounce: 3-cycle glitch rejected, 4-cycle pulse accepted
        pins_in = 16'h0003;
        step(3);
        pins_in = 16'h0001;
        push("glitch_din", O_DIN, 16'h0002, 16'h0000);
        push("glitch_stat", O_STAT, 16'h0002, 16'h0000);
        step(10);
        drain();
        pins_in = 16'h0003;
        step(4);
        pins_in = 16'h0001;
        push("pulse_din_rise", O_DIN, 16'h0002, 16'h0002);
        step(2);
        drain();
        push("pulse_stat", O_STAT, 16'h0002, 16'h0002);
        push("pulse_irq_masked", O_IRQ, 16'h0001, 16'h0000);
        step(1);
        drain();
        push("pulse_din_hold", O_DIN, 16'h0002, 16'h0002);
        step(2);
        drain();
        push("pulse_din_fall", O_DIN, 16'h0002, 16'h0000);
        step(1);
        drain();
        wr(4'd9, 16'h0002);

        // Both-edge mode on pin 2
        wr(4'd8, 16'h0004);
        pins_in = 16'h0005;
        push("both_rise_k6", O_STAT, 16'h0004, 16'h0000);
        step(6);
        drain();
        push("both_rise_k7", O_STAT, 16'h0004, 16'h0004);
        step(1);
        drain();
        wr(4'd9, 16'h0004);
        push("both_w1c", O_STAT, 16'h0004, 16'h0000);
        drain();
        step(2);
        pins_in = 16'h0001;
        push("both_fall_k6", O_STAT, 16'h0004, 16'h0000);
        step(6);
        drain();
        push("both_fall_k7", O_STAT, 16'h0004, 16'h0004);
        step(1);
        drain();
        wr(4'd9, 16'h0004);

        // Level-high mode on pin 3
        wr(4'd7, 16'h0008);
        wr(4'd6, 16'h0008);
        pins_in = 16'h0009;
        push("lvl_set", O_STAT, 16'h0008, 16'h0008);
        step(7);
        drain();
        wr(4'd9, 16'h0008);
        push("lvl_w1c_clear", O_STAT, 16'h0008, 16'h0000);
        drain();
        push("lvl_reset", O_STAT, 16'h0008, 16'h0008);
        step(1);
        drain();
        pins_in = 16'h0001;
        push("lvl_sticky", O_STAT, 16'h0008, 16'h0008);
        step(8);
        drain();
        wr(4'd9, 16'h0008);
        push("lvl_w1c_low", O_STAT, 16'h0008, 16'h0000);
        step(3);
        drain();
        wr(4'd6, 16'h0000);
        wr(4'd7, 16'h0000);

        // Set beats a same-cycle W1C
        pins_in = 16'h0000;
        step(10);
        wr(4'd9, 16'h0001);
        pins_in = 16'h0001;
        step(6);
        wr(4'd9, 16'h0001);
        push("set_wins_stat", O_STAT, 16'h0001, 16'h0001);
        push("set_wins_irq", O_IRQ, 16'h0001, 16'h0001);
        drain();
        wr(4'd9, 16'h0001);
        push("set_wins_clear", O_STAT, 16'h0001, 16'h0000);
        drain();

        // Reset mid-debounce on pin 5
        wr(4'd4, 16'h00F0);
        wr(4'd0, 16'h00F0);
        pins_in = 16'h0021;
        step(3);
        reset = 1'b0;
        push("mid_rst_out", O_OUT, 16'hFFFF, 16'h0000);
        push("mid_rst_oe", O_OE, 16'hFFFF, 16'h0000);
        push("mid_rst_dir", O_DIR, 16'hFFFF, 16'h0000);
        push("mid_rst_din", O_DIN, 16'hFFFF, 16'h0000);
        push("mid_rst_stat", O_STAT, 16'hFFFF, 16'h0000);
        push("mid_rst_irq", O_IRQ, 16'h0001, 16'h0000);
        step(1);
        drain();
        pins_in = 16'h0000;
        reset   = 1'b1;
        push("post_rst_stat", O_STAT, 16'hFFFF, 16'h0000);
        push("post_rst_din", O_DIN, 16'hFFFF, 16'h0000);
        step(12);
        drain();
        pins_in = 16'h0020;
        push("p5_new_edge", O_STAT, 16'hFFFF, 16'h0020);
        push("p5_irq_masked", O_IRQ, 16'h0001, 16'h0000);
        step(7);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gpio_bank.md
Name: gpio_bank

Overview:
- Parametrised next-generation GPIO bank: WIDTH pins with per-pin direction, atomic set/clear/toggle output writes, and input synchronisation plus debounce.
- Per-pin interrupt modes (rising / falling / both edges / high level / low level) with a sticky write-1-to-clear status register and a single combined IRQ.
- Sits between the register-bus decoder and the pad ring.
- Alternate-function muxing stays outside this block.

Parameters:
- WIDTH, 16, number of pins in the bank.
- SYNC_STAGES, 2, flip-flop stages in each input synchroniser (minimum 2).
- DEBOUNCE_CYC, 4, consecutive stable cycles needed before the filtered input changes; 0 bypasses the debounce.

Ports:
- clk  in  1  system clock.
- reset  in  1  reset: synchronous, active-low.
- wr_en  in  1  register write strobe, one cycle per write.
- wr_sel  in  4  write target select: 0 DATA, 1 SET, 2 CLR, 3 TOG, 4 DIR, 5 IRQ_EN, 6 IRQ_TYPE, 7 IRQ_POL, 8 IRQ_BOTH, 9 IRQ_W1C. Values 10-15 are ignored.
- wr_data  in  WIDTH  write payload.
- pins_in  in  WIDTH  asynchronous pad inputs.
- pins_out  out  WIDTH  output data register to the pads.
- pins_oe  out  WIDTH  output enable (= DIR; 1 = output).
- data_in  out  WIDTH  readback: filtered input where DIR=0, pins_out where DIR=1.
- dir_q  out  WIDTH  DIR register readback.
- irq_status  out  WIDTH  sticky interrupt status.
- irq  out  1  OR over (irq_status & IRQ_EN).

Behaviour:
- Reset (reset=0 sampled at a clk edge):
  - Cleared to 0: DATA, DIR, IRQ_EN, IRQ_TYPE, IRQ_POL, IRQ_BOTH, irq_status, all synchroniser stages, filtered inputs, previous-filtered register and debounce counters.
  - Outputs after reset: pins_out=0, pins_oe=0, irq=0.
  - A reset asserted mid-debounce or mid-write discards the operation; no partial update.
- Register writes take effect on the clk edge where wr_en=1. Per select:
  - DATA: DATA := wr_data.
  - SET: DATA := DATA | wr_data.
  - CLR: DATA := DATA & ~wr_data.
  - TOG: DATA := DATA ^ wr_data.
  - DIR, IRQ_EN, IRQ_TYPE, IRQ_POL, IRQ_BOTH: plain load of wr_data.
  - IRQ_W1C: clears each status bit where wr_data=1.
  - pins_out and pins_oe change on the cycle after the write edge (registered).
- Input path, per pin:
  - Stage 1 is a SYNC_STAGES flop chain producing s.
  - Stage 2 is a debounce counter, width clog2(DEBOUNCE_CYC+1). While s == filt the counter is held at 0. While s != filt the counter increments. When the counter reaches DEBOUNCE_CYC-1 and s still differs, filt := s and the counter is reset to 0.
  - Any glitch shorter than DEBOUNCE_CYC cycles (s returns to filt) zeroes the counter with no change to filt.
  - With DEBOUNCE_CYC=0, filt := s every cycle.
- Latency: a pins_in change stable from edge k appears on filt/data_in at edge k+SYNC_STAGES+DEBOUNCE_CYC (default k+6). irq_status sets one edge later (default k+7).
- Event detection uses prev := filt registered every cycle.
  - Edge mode (IRQ_TYPE=0), IRQ_BOTH=1: event on any filt != prev.
  - Edge mode, IRQ_BOTH=0, IRQ_POL=0: event on rising (filt & ~prev).
  - Edge mode, IRQ_BOTH=0, IRQ_POL=1: event on falling.
  - Level mode (IRQ_TYPE=1): event every cycle filt == IRQ_POL (IRQ_POL=1 means high level).
- Status:
  - Status is set by an event regardless of IRQ_EN; IRQ_EN masks only irq.
  - If a set and a W1C hit the same bit in the same cycle, the set wins.
  - In level mode a W1C takes effect only once the level is inactive; while the level persists the bit re-sets on the next cycle.
- Events are also detected on pins with DIR=1. The filtered input still tracks the pad, so an output can loop back as an interrupt.
- irq is combinational from the registered irq_status and IRQ_EN, so it has no extra latency.
- A pin held high through reset shows a rising event after reset release. Software clears it before setting IRQ_EN.

Test Plan:
- Reset with pins_in=0xFFFF, then set DIR=0x00FF, DATA=0x00A5, SET=0x0100, CLR=0x0004, TOG=0x0003 -> pins_out=0x01A2, pins_oe=0x00FF, dir_q=0x00FF, each one cycle after its write.
- Defaults, IRQ_EN=0x0001, rising mode; pins_in[0] 0->1 at edge k -> data_in[0]=1 at k+6, irq_status[0]=1 and irq=1 at k+7. Then W1C 0x0001 -> irq_status=0, irq=0 next cycle.
- pins_in[1] high-pulse of 3 cycles (after the synchroniser), DEBOUNCE_CYC=4 -> data_in[1] stays 0 and irq_status[1] stays 0. A 4-cycle pulse -> data_in[1] rises, then falls after the pulse ends.
- IRQ_BOTH=0x0004, pin 2 toggles 0->1->0 with 10-cycle spacing -> irq_status[2] set after each edge. A W1C between the edges clears it, and it re-sets on the second edge.
- IRQ_TYPE=IRQ_POL=0x0008, pin 3 held high -> irq_status[3] set; a W1C while high sees the bit clear for 1 cycle, then re-set. W1C after the pin is low -> stays 0.
- An event on pin 0 coinciding with a W1C of bit 0 -> irq_status[0]=1 (set wins). Assert reset mid-debounce on pin 5 -> all outputs 0 next cycle, no event afterwards until a new qualified edge.
